mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_arb_pkg.sv | 13 +
 rtl/mem_port_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default tuning constants for the fetch/data memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } arb_state_t;

    localparam int STARVE_MAX_DEF = 4;
    localparam int TIMEOUT_DEF    = 16;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and data stages onto one memory port, with a starvation
// guard for fetch and a watchdog that aborts accesses the memory never acknowledges.
import mem_arb_pkg::*;

module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = STARVE_MAX_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_done,
    output logic [DW-1:0] if_rdata,
    output logic          stall_if,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_done,
    output logic [DW-1:0] dm_rdata,
    output logic          stall_mem,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic          err_timeout
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    arb_state_t    state, state_nxt;
    logic [SW-1:0] starve_cnt;
    logic [WW-1:0] wd_cnt;
    logic          lat_we;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic          err_q;

    logic busy, active, wd_expired, finish, starved, grant_dm, grant_if;

    // Grants only happen in IDLE; reset overrides any grant through the state register.
    always_comb begin
        busy       = (state != IDLE);
        active     = busy && !rst;
        wd_expired = busy && !mem_ack && (wd_cnt == WW'(TIMEOUT - 1));
        finish     = busy && (mem_ack || wd_expired);
        starved    = (starve_cnt == SW'(STARVE_MAX));
        grant_dm   = (state == IDLE) && !rst && dm_req && !(if_req && starved);
        grant_if   = (state == IDLE) && !rst && if_req && !grant_dm;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_dm)
                    state_nxt = BUSY_DM;
                else if (grant_if)
                    state_nxt = BUSY_IF;
            end
            BUSY_IF, BUSY_DM: begin
                if (finish)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            wd_cnt     <= '0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            err_q      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (grant_dm) begin
                lat_we    <= dm_we;
                lat_addr  <= dm_addr;
                lat_wdata <= dm_wdata;
                if (if_req && !starved)
                    starve_cnt <= starve_cnt + SW'(1);
            end else if (grant_if) begin
                lat_we     <= 1'b0;
                lat_addr   <= if_addr;
                lat_wdata  <= '0;
                starve_cnt <= '0;
            end
            if (grant_dm || grant_if)
                wd_cnt <= '0;
            else if (busy && !mem_ack)
                wd_cnt <= wd_cnt + WW'(1);
            if (wd_expired)
                err_q <= 1'b1;
        end
    end

    // The memory side sees only the latched request, and nothing at all while reset is held.
    always_comb begin
        mem_req     = active;
        mem_we      = active && lat_we;
        mem_addr    = active ? lat_addr : '0;
        mem_wdata   = active ? lat_wdata : '0;
        if_done     = active && (state == BUSY_IF) && (mem_ack || wd_expired);
        dm_done     = active && (state == BUSY_DM) && (mem_ack || wd_expired);
        if_rdata    = (active && (state == BUSY_IF) && mem_ack) ? mem_rdata : '0;
        dm_rdata    = (active && (state == BUSY_DM) && mem_ack) ? mem_rdata : '0;
        stall_if    = if_req && !if_done;
        stall_mem   = dm_req && !dm_done;
        err_timeout = err_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reads, writes, starvation, timeout, reset and spurious acks.
import mem_arb_pkg::*;

module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_rdata;
    logic        stall_if;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_done;
    logic [31:0] dm_rdata;
    logic        stall_mem;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        err_timeout;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.AW(32), .DW(32), .STARVE_MAX(4), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata), .stall_if(stall_if),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_done(dm_done), .dm_rdata(dm_rdata), .stall_mem(stall_mem),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .err_timeout(err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic ireq, input logic [31:0] iaddr,
                                 input logic dreq, input logic dwe, input logic [31:0] daddr,
                                 input logic [31:0] dwdata, input logic ack, input logic [31:0] rdata);
        if_req    = ireq;
        if_addr   = iaddr;
        dm_req    = dreq;
        dm_we     = dwe;
        dm_addr   = daddr;
        dm_wdata  = dwdata;
        mem_ack   = ack;
        mem_rdata = rdata;
        #1;
    endtask

    task automatic waitCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        waitCycle();
        waitCycle();
        checkOutput("rst_mem_req", mem_req, 0);
        checkOutput("rst_if_done", if_done, 0);
        checkOutput("rst_stall_if", stall_if, 1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        waitCycle();
        rst = 1'b0;
        #1;
        checkOutput("rst_state", dut.state, IDLE);
        checkOutput("rst_err", err_timeout, 0);
        checkOutput("rst_mem_addr", mem_addr, 0);

        // IF-only read
        applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        checkOutput("if_c0_stall", stall_if, 1);
        checkOutput("if_c0_mem_req", mem_req, 0);
        waitCycle();
        applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hDEADBEEF);
        checkOutput("if_c1_mem_req", mem_req, 1);
        checkOutput("if_c1_mem_addr", mem_addr, 32'h100);
        checkOutput("if_c1_mem_we", mem_we, 0);
        checkOutput("if_c1_done", if_done, 1);
        checkOutput("if_c1_rdata", if_rdata, 32'hDEADBEEF);
        checkOutput("if_c1_stall", stall_if, 0);
        waitCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        checkOutput("if_c2_mem_req", mem_req, 0);
        checkOutput("if_c2_mem_addr", mem_addr, 0);

        // Simultaneous requests: DM write first, then IF
        applyStimulus(1'b1, 32'h200, 1'b1, 1'b1, 32'h40, 32'h5, 1'b0, 32'h0);
        checkOutput("sim_stall_mem", stall_mem, 1);
        waitCycle();
        checkOutput("sim_dm_mem_req", mem_req, 1);
        checkOutput("sim_dm_mem_we", mem_we, 1);
        checkOutput("sim_dm_mem_addr", mem_addr, 32'h40);
        checkOutput("sim_dm_mem_wdata", mem_wdata, 32'h5);
        checkOutput("sim_dm_no_done", dm_done, 0);
        applyStimulus(1'b1, 32'h200, 1'b1, 1'b1, 32'h44, 32'h9, 1'b0, 32'h0);
        checkOutput("sim_payload_addr", mem_addr, 32'h40);
        checkOutput("sim_payload_wdata", mem_wdata, 32'h5);
        waitCycle();
        applyStimulus(1'b1, 32'h200, 1'b1, 1'b1, 32'h44, 32'h9, 1'b1, 32'h1234);
        checkOutput("sim_dm_done", dm_done, 1);
        checkOutput("sim_dm_rdata", dm_rdata, 32'h1234);
        checkOutput("sim_if_not_done", if_done, 0);
        checkOutput("sim_if_rdata_zero", if_rdata, 0);
        checkOutput("sim_stall_if", stall_if, 1);
        waitCycle();
        applyStimulus(1'b1, 32'h200, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        checkOutput("sim_gap_mem_req", mem_req, 0);
        checkOutput("sim_starve_one", dut.starve_cnt, 1);
        waitCycle();
        checkOutput("sim_if_mem_addr", mem_addr, 32'h200);
        checkOutput("sim_if_mem_we", mem_we, 0);
        checkOutput("sim_starve_clr", dut.starve_cnt, 0);
        applyStimulus(1'b1, 32'h200, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hCAFE);
        checkOutput("sim_if_done", if_done, 1);
        checkOutput("sim_if_rdata", if_rdata, 32'hCAFE);
        waitCycle();

        // Fetch starvation: four DM grants, then IF
        applyStimulus(1'b1, 32'h300, 1'b1, 1'b0, 32'h80, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            waitCycle();
            checkOutput($sformatf("starve_addr_%0d", i), mem_addr, (i < 4) ? 32'h80 : 32'h300);
            checkOutput($sformatf("starve_cnt_%0d", i), dut.starve_cnt, (i < 4) ? i + 1 : 0);
            mem_ack = 1'b1;
            #1;
            checkOutput($sformatf("starve_dm_done_%0d", i), dm_done, (i < 4) ? 1 : 0);
            checkOutput($sformatf("starve_if_done_%0d", i), if_done, (i < 4) ? 0 : 1);
            waitCycle();
            mem_ack = 1'b0;
            #1;
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        waitCycle();

        // Watchdog timeout on a DM read that is never acknowledged
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h500, 32'h0, 1'b0, 32'hFFFF);
        waitCycle();
        for (int c = 1; c <= 16; c++) begin
            checkOutput($sformatf("to_done_c%0d", c), dm_done, (c == 16) ? 1 : 0);
            if (c < 16)
                waitCycle();
        end
        checkOutput("to_rdata_zero", dm_rdata, 0);
        checkOutput("to_err_before_edge", err_timeout, 0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'hFFFF);
        waitCycle();
        checkOutput("to_err_set", err_timeout, 1);
        checkOutput("to_state_idle", dut.state, IDLE);
        checkOutput("to_mem_req", mem_req, 0);
        waitCycle();
        checkOutput("to_err_sticky", err_timeout, 1);

        // Spurious ack while idle
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hAA);
        checkOutput("spur_if_done", if_done, 0);
        checkOutput("spur_dm_done", dm_done, 0);
        checkOutput("spur_if_rdata", if_rdata, 0);
        waitCycle();
        checkOutput("spur_state", dut.state, IDLE);
        checkOutput("spur_mem_req", mem_req, 0);

        // Reset in the middle of an IF access
        applyStimulus(1'b1, 32'h600, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        waitCycle();
        checkOutput("mid_busy_c1", mem_req, 1);
        waitCycle();
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_mem_req", mem_req, 0);
        checkOutput("mid_rst_done", if_done, 0);
        checkOutput("mid_rst_stall", stall_if, 1);
        waitCycle();
        rst = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h77);
        checkOutput("mid_after_mem_req", mem_req, 0);
        checkOutput("mid_after_state", dut.state, IDLE);
        checkOutput("mid_after_err", err_timeout, 0);
        checkOutput("mid_after_done", if_done, 0);
        waitCycle();
        checkOutput("mid_ack_ignored", dut.state, IDLE);
        checkOutput("mid_ack_no_req", mem_req, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
